// File: rtl/sm_ahb_ram_slave_pkg.sv
// rtl/sm_ahb_ram_slave_pkg.sv - AHB-Lite encodings and address check shared by the RAM responder
//
// Purpose: HTRANS/HRESP encodings and the word-address legality check used at
//          the address phase of the AHB-Lite RAM responder.
// Ports:   none (package).

package sm_ahb_ram_slave_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // A transfer is bad when it is not word aligned or addresses beyond the
    // RAM; the RAM only supports whole-word accesses.
    function automatic logic addr_bad(input logic [31:0] haddr, input int unsigned addr_width);
        return ((haddr >> (addr_width + 2)) != 32'd0) || (haddr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/sm_ram_1r1w.sv
// rtl/sm_ram_1r1w.sv - word RAM with one synchronous write port and one asynchronous read port
//
// Purpose: storage behind the AHB-Lite responder; contents are not reset.
// Ports:
//   clk    in   1            clock
//   we     in   1            write enable, commits wdata at the rising edge
//   waddr  in   ADDR_WIDTH   write word address
//   wdata  in   DATA_WIDTH   write data
//   raddr  in   ADDR_WIDTH   read word address
//   rdata  out  DATA_WIDTH   combinational read data

module sm_ram_1r1w #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sm_ahb_ram_slave.sv
// rtl/sm_ahb_ram_slave.sv - AHB-Lite word RAM responder with programmable wait states and ERROR response
//
// Purpose: completes single AHB-Lite transfers (back-to-back allowed) against a
//          2**ADDR_WIDTH word RAM, inserting WAIT_STATES low-ready cycles in each
//          OKAY data phase and a two-cycle ERROR response for unaligned or
//          out-of-range addresses.
// Ports:
//   HCLK       in   1    clock
//   HRESETn    in   1    asynchronous active-low reset
//   HSEL       in   1    slave select (address phase)
//   HADDR      in   32   byte address (address phase)
//   HWRITE     in   1    1=write, 0=read (address phase)
//   HTRANS     in   2    transfer type; only bit 1 matters (BUSY=IDLE, SEQ=NONSEQ)
//   HREADY     in   1    bus-wide ready
//   HWDATA     in   32   write data (data phase)
//   HRDATA     out  32   read data (data phase), 0 when not completing a read
//   HREADYOUT  out  1    data-phase ready
//   HRESP      out  1    0=OKAY, 1=ERROR

module sm_ahb_ram_slave
    import sm_ahb_ram_slave_pkg::*;
#(
    parameter int ADDR_WIDTH  = 6,
    parameter int WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic        HWRITE,
    input  logic [1:0]  HTRANS,
    input  logic        HREADY,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_t;

    localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t                state;
    logic [3:0]            wait_cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  write_q;

    logic                  can_accept;
    logic                  accept;
    logic                  bad;
    logic                  ram_we;
    logic [31:0]           ram_rdata;
    logic                  unused_htrans_lsb;

    // BUSY is folded into IDLE and SEQ into NONSEQ, so only HTRANS[1] decides.
    assign unused_htrans_lsb = HTRANS[0];

    // A new address phase can only be taken in a cycle where this slave drives
    // HREADYOUT high: idle, or the last cycle of an OKAY or ERROR response.
    assign can_accept = (state == ST_IDLE) || (state == ST_DATA) || (state == ST_ERR2);
    assign accept     = can_accept && HSEL && HTRANS[1] && HREADY;
    assign bad        = addr_bad(HADDR, ADDR_WIDTH);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state    <= ST_IDLE;
            wait_cnt <= 4'd0;
            addr_q   <= '0;
            write_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DATA, ST_ERR2: begin
                    if (accept) begin
                        addr_q  <= HADDR[ADDR_WIDTH+1:2];
                        write_q <= HWRITE;
                        if (bad) begin
                            state <= ST_ERR1;
                        end else if (WAIT_STATES > 0) begin
                            state    <= ST_WAIT;
                            wait_cnt <= WAIT_INIT;
                        end else begin
                            state <= ST_DATA;
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state <= ST_DATA;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_ERR1: begin
                    state <= ST_ERR2;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Responses are decoded straight from the state register so a reset
    // returns them to OKAY/ready in the same cycle.
    assign HREADYOUT = !((state == ST_WAIT) || (state == ST_ERR1));
    assign HRESP     = ((state == ST_ERR1) || (state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;

    // Bad transfers never reach ST_DATA, so they can never write the RAM.
    assign ram_we = (state == ST_DATA) && write_q;

    sm_ram_1r1w #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (32)
    ) u_ram (
        .clk   (HCLK),
        .we    (ram_we),
        .waddr (addr_q),
        .wdata (HWDATA),
        .raddr (addr_q),
        .rdata (ram_rdata)
    );

    assign HRDATA = ((state == ST_DATA) && !write_q) ? ram_rdata : 32'd0;

endmodule

// File: tb/tb_sm_ahb_ram_slave.sv
// tb/tb_sm_ahb_ram_slave.sv - self-checking bench for sm_ahb_ram_slave (zero and two wait states)

module tb_sm_ahb_ram_slave;

    logic        clk;
    logic        rst0_n;
    logic        rst2_n;
    logic        hsel0;
    logic        hsel2;
    logic [31:0] haddr;
    logic        hwrite;
    logic [1:0]  htrans;
    logic [31:0] hwdata;

    logic [31:0] hrdata0;
    logic        hreadyout0;
    logic        hresp0;
    logic [31:0] hrdata2;
    logic        hreadyout2;
    logic        hresp2;

    int vectors;
    int miscompares;

    typedef struct {
        int          waits;
        logic        resp;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    logic [31:0] model0 [logic [31:0]];

    logic [31:0] op_addr [4];
    logic        op_wr   [4];
    logic [31:0] op_data [4];

    sm_ahb_ram_slave #(.ADDR_WIDTH(6), .WAIT_STATES(0)) dut0 (
        .HCLK      (clk),
        .HRESETn   (rst0_n),
        .HSEL      (hsel0),
        .HADDR     (haddr),
        .HWRITE    (hwrite),
        .HTRANS    (htrans),
        .HREADY    (hreadyout0),
        .HWDATA    (hwdata),
        .HRDATA    (hrdata0),
        .HREADYOUT (hreadyout0),
        .HRESP     (hresp0)
    );

    sm_ahb_ram_slave #(.ADDR_WIDTH(6), .WAIT_STATES(2)) dut2 (
        .HCLK      (clk),
        .HRESETn   (rst2_n),
        .HSEL      (hsel2),
        .HADDR     (haddr),
        .HWRITE    (hwrite),
        .HTRANS    (htrans),
        .HREADY    (hreadyout2),
        .HWDATA    (hwdata),
        .HRDATA    (hrdata2),
        .HREADYOUT (hreadyout2),
        .HRESP     (hresp2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Single transfer on dut0 (d=0) or dut2 (d=2); the expected response is
    // queued when the address phase is driven and retired at completion.
    task automatic xfer(input int d, input logic [31:0] a, input logic w, input logic [31:0] wd,
                        input int ew, input logic eresp, input logic [31:0] erd, input string tag);
        exp_t e;
        int   n;
        bit   done;
        sb.push_back('{waits: ew, resp: eresp, rdata: erd});
        if (d == 0) hsel0 = 1'b1; else hsel2 = 1'b1;
        haddr  = a;
        hwrite = w;
        htrans = 2'b10;
        @(posedge clk); #1;
        hsel0  = 1'b0;
        hsel2  = 1'b0;
        htrans = 2'b00;
        haddr  = 32'd0;
        hwrite = 1'b0;
        hwdata = wd;
        e      = sb.pop_front();
        n      = 0;
        done   = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if ((d == 0 ? hreadyout0 : hreadyout2) === 1'b1) begin
                done = 1'b1;
            end else begin
                n++;
                check({tag, " resp_in_wait"}, 32'(d == 0 ? hresp0 : hresp2), 32'(e.resp));
            end
        end
        check({tag, " completed"}, 32'(done), 32'd1);
        check({tag, " wait_cycles"}, n, e.waits);
        check({tag, " resp"}, 32'(d == 0 ? hresp0 : hresp2), 32'(e.resp));
        check({tag, " rdata"}, (d == 0 ? hrdata0 : hrdata2), e.rdata);
        @(posedge clk); #1;
    endtask

    // Pipelined back-to-back transfers on dut0 (zero wait states).
    task automatic pipe(input int n, input string tag);
        exp_t e;
        for (int i = 0; i <= n; i++) begin
            if (i < n) begin
                hsel0  = 1'b1;
                htrans = 2'b10;
                haddr  = op_addr[i];
                hwrite = op_wr[i];
                if (op_wr[i]) begin
                    sb.push_back('{waits: 0, resp: 1'b0, rdata: 32'd0});
                    model0[op_addr[i]] = op_data[i];
                end else begin
                    sb.push_back('{waits: 0, resp: 1'b0, rdata: model0[op_addr[i]]});
                end
            end else begin
                hsel0  = 1'b0;
                htrans = 2'b00;
                haddr  = 32'd0;
                hwrite = 1'b0;
            end
            if (i > 0) hwdata = op_data[i-1];
            @(negedge clk);
            check($sformatf("%s ready[%0d]", tag, i), 32'(hreadyout0), 32'd1);
            if (i > 0) begin
                e = sb.pop_front();
                check($sformatf("%s resp[%0d]", tag, i - 1), 32'(hresp0), 32'(e.resp));
                check($sformatf("%s rdata[%0d]", tag, i - 1), hrdata0, e.rdata);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst0_n = 1'b0;
        rst2_n = 1'b0;
        hsel0  = 1'b0;
        hsel2  = 1'b0;
        haddr  = 32'd0;
        hwrite = 1'b0;
        htrans = 2'b00;
        hwdata = 32'd0;
        @(posedge clk); @(posedge clk); #1;

        check("reset ready0", 32'(hreadyout0), 32'd1);
        check("reset resp0",  32'(hresp0),     32'd0);
        check("reset rdata0", hrdata0,         32'd0);
        check("reset ready2", 32'(hreadyout2), 32'd1);
        rst0_n = 1'b1;
        rst2_n = 1'b1;
        @(posedge clk); #1;

        // Write then read, zero wait states, pipelined.
        op_addr[0] = 32'h10; op_wr[0] = 1'b1; op_data[0] = 32'hDEADBEEF;
        op_addr[1] = 32'h10; op_wr[1] = 1'b0; op_data[1] = 32'h0;
        pipe(2, "t1");

        // Back-to-back writes then reads.
        op_addr[0] = 32'h20; op_wr[0] = 1'b1; op_data[0] = 32'h1;
        op_addr[1] = 32'h24; op_wr[1] = 1'b1; op_data[1] = 32'h2;
        op_addr[2] = 32'h20; op_wr[2] = 1'b0; op_data[2] = 32'h0;
        op_addr[3] = 32'h24; op_wr[3] = 1'b0; op_data[3] = 32'h0;
        pipe(4, "t5");

        // Out-of-range and unaligned writes must answer ERROR and leave word 0 intact.
        xfer(0, 32'h00,  1'b1, 32'h11112222, 0, 1'b0, 32'h0,        "t3 prewrite");
        xfer(0, 32'h400, 1'b1, 32'hBAD0BAD0, 1, 1'b1, 32'h0,        "t3 err");
        xfer(0, 32'h00,  1'b0, 32'h0,        0, 1'b0, 32'h11112222, "t3 readback");
        xfer(0, 32'h02,  1'b1, 32'h0BADF00D, 1, 1'b1, 32'h0,        "t4 err");
        xfer(0, 32'h00,  1'b0, 32'h0,        0, 1'b0, 32'h11112222, "t4 readback");
        xfer(0, 32'hFC,  1'b1, 32'h7777AAAA, 0, 1'b0, 32'h0,        "top write");
        xfer(0, 32'hFC,  1'b0, 32'h0,        0, 1'b0, 32'h7777AAAA, "top read");

        // Two wait states.
        xfer(2, 32'h04, 1'b1, 32'hCAFEF00D, 2, 1'b0, 32'h0,        "t2 write");
        xfer(2, 32'h04, 1'b0, 32'h0,        2, 1'b0, 32'hCAFEF00D, "t2 read");
        xfer(2, 32'h08, 1'b1, 32'h12345678, 2, 1'b0, 32'h0,        "t6 prewrite");

        // Reset during a wait state drops the pending write.
        hsel2  = 1'b1;
        haddr  = 32'h08;
        hwrite = 1'b1;
        htrans = 2'b10;
        @(posedge clk); #1;
        hsel2  = 1'b0;
        htrans = 2'b00;
        haddr  = 32'd0;
        hwrite = 1'b0;
        hwdata = 32'h00000055;
        check("t6 waiting", 32'(hreadyout2), 32'd0);
        rst2_n = 1'b0;
        #1;
        check("t6 reset ready", 32'(hreadyout2), 32'd1);
        check("t6 reset resp",  32'(hresp2),     32'd0);
        check("t6 reset rdata", hrdata2,         32'd0);
        @(posedge clk); #1;
        rst2_n = 1'b1;
        @(negedge clk);
        check("t6 idle ready", 32'(hreadyout2), 32'd1);
        @(posedge clk); #1;
        xfer(2, 32'h08, 1'b0, 32'h0, 2, 1'b0, 32'h12345678, "t6 readback");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
